// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver with mid-bit sampling and a one-cycle done strobe.
// Define UART_RX_FRAME_CHECK_EN to enable stop-bit checking, frame_err and the ERR state.
module uart_recv #(
  parameter int CLK_FREQ = 12000000,
  parameter int UART_BPS = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       uart_done,
  output logic       rx_busy,
  output logic       frame_err
);
  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam logic [15:0] CNT_END = 16'(BPS_CNT - 1);
  localparam logic [15:0] CNT_MID = 16'(BPS_CNT / 2);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
`ifdef UART_RX_FRAME_CHECK_EN
  localparam logic [2:0] ERR   = 3'd4;
`endif
  logic        rxd_d0, rxd_d1, rxd_d2;
  logic [2:0]  state, nxt;
  logic [15:0] clk_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic        start_flag, mid, wrap, run, last, stop_ok;
  assign start_flag = rxd_d2 & ~rxd_d1;
  assign mid        = clk_cnt == CNT_MID;
  assign wrap       = clk_cnt == CNT_END;
  assign rx_busy    = state == START || state == DATA || state == STOP;
  assign run        = state != IDLE && (nxt == START || nxt == DATA || nxt == STOP);
  assign last       = state == STOP && mid;
`ifdef UART_RX_FRAME_CHECK_EN
  assign stop_ok    = rxd_d1;
`else
  assign stop_ok    = 1'b1;
`endif
  // synchroniser resets high so the release of reset never looks like a falling edge
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) {rxd_d0, rxd_d1, rxd_d2} <= 3'b111;
    else {rxd_d0, rxd_d1, rxd_d2} <= {uart_rxd, rxd_d0, rxd_d1};
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = start_flag ? START : IDLE;
      START: nxt = (mid && rxd_d1) ? IDLE : wrap ? DATA : START;
      DATA:  nxt = (wrap && bit_cnt == 4'd8) ? STOP : DATA;
`ifdef UART_RX_FRAME_CHECK_EN
      STOP:  nxt = mid ? (stop_ok ? IDLE : ERR) : STOP;
      ERR:   nxt = rxd_d1 ? IDLE : ERR;
`else
      STOP:  nxt = mid ? IDLE : STOP;
`endif
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      uart_data <= '0;
      uart_done <= 1'b0;
    end else begin
      state     <= nxt;
      clk_cnt   <= (!run || wrap) ? '0 : clk_cnt + 16'd1;
      bit_cnt   <= !run ? '0 : wrap ? bit_cnt + 4'd1 : bit_cnt;
      if (state == DATA && mid) shift <= {rxd_d1, shift[7:1]};
      if (last && stop_ok) uart_data <= shift;
      uart_done <= last && stop_ok;
    end
`ifdef UART_RX_FRAME_CHECK_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) frame_err <= 1'b0;
    else frame_err <= last && !rxd_d1;
`else
  assign frame_err = 1'b0;
`endif
endmodule
